// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and the inverse S-box table used by the
// decryption datapath.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } inv_sb_state_e;

  localparam int AES_STATE_BYTES = 16;

  // Inverse S-box, indexed by the substituted byte value.
  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Single-byte combinational inverse S-box lookup.
module inv_sbox
  import aes_pkg::*;
(
  input  aes_byte_t in_byte,
  output aes_byte_t out_byte
);

  assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// Iterative InvSubBytes: accepts one 128-bit state, substitutes
// BYTES_PER_CYCLE bytes per clock (lowest index first), then holds the
// result until the downstream accepts it.
module inv_sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int NUM_STEPS = AES_STATE_BYTES / BYTES_PER_CYCLE;
  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("inv_sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  inv_sb_state_e state_q, state_d;
  aes_state_t    work_q, work_d;
  logic [3:0]    step_q, step_d;
  aes_byte_t     lut_in  [BYTES_PER_CYCLE];
  aes_byte_t     lut_out [BYTES_PER_CYCLE];

  // Pick out the bytes belonging to the current step for the lookups.
  always_comb begin
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      lut_in[j] = work_q[8 * (int'(step_q) * BYTES_PER_CYCLE + j) +: 8];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lut
    inv_sbox u_inv_sbox (
      .in_byte  (lut_in[g]),
      .out_byte (lut_out[g])
    );
  end

  // Next-state logic: latch in IDLE, write back substituted bytes in BUSY,
  // hold the result in DONE until out_ready.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          step_d  = 4'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          work_d[8 * (int'(step_q) * BYTES_PER_CYCLE + j) +: 8] = lut_out[j];
        end
        if (step_q == LAST_STEP) begin
          step_d  = 4'd0;
          state_d = DONE;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Working register is pure data; its contents only become visible in DONE.
  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign state_out = (state_q == DONE) ? work_q : '0;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Bench for inv_sub_bytes_engine at BPC=4, 1 and 16 plus the standalone
// inv_sbox; reference tables are derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready;
  logic [127:0] state_in;
  logic         r4, v4, b4, r1, v1, b1, r16, v16, b16;
  logic [127:0] o4, o1, o16;
  logic [7:0]   sb_in, sb_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_tab [256];
  logic [7:0] inv_tab  [256];

  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r4), .state_in(state_in),
    .out_valid(v4), .out_ready(out_ready), .state_out(o4), .busy(b4));
  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .state_in(state_in),
    .out_valid(v1), .out_ready(out_ready), .state_out(o1), .busy(b1));
  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r16), .state_in(state_in),
    .out_valid(v16), .out_ready(out_ready), .state_out(o16), .busy(b16));
  inv_sbox u_sbox (.in_byte(sb_in), .out_byte(sb_out));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box = affine(multiplicative inverse); inverse table by inversion.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_tab[x] = s;
      inv_tab[s]  = 8'(x);
    end
  endtask

  function automatic logic [127:0] exp_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] s);
    state_in = s;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic settle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; state_in = '0;
    repeat (3) step();
    checks++; if (r4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", r4); end
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", v4); end
    checks++; if (b4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b4); end
    checks++; if (o4 !== 128'h0) begin errors++; $display("FAIL reset_state_out got %h want 0", o4); end
    checks++; if (v1 !== 1'b0 || v16 !== 1'b0) begin errors++; $display("FAIL reset_out_valid_bpc1_16 got %b%b want 00", v1, v16); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_inv_sbox();
    logic [7:0] ins  [7] = '{8'hd4, 8'h10, 8'h63, 8'h7c, 8'h16, 8'h00, 8'hff};
    logic [7:0] outs [7] = '{8'h19, 8'h7c, 8'h00, 8'h01, 8'hff, 8'h52, 8'h7d};
    logic [7:0] r;
    for (int i = 0; i < 7; i++) begin
      sb_in = ins[i];
      #1;
      checks++; if (sb_out !== outs[i]) begin errors++; $display("FAIL inv_sbox_known in=%h got %h want %h", ins[i], sb_out, outs[i]); end
    end
    for (int i = 0; i < 16; i++) begin
      r = 8'($urandom);
      sb_in = r;
      #1;
      checks++; if (sb_out !== inv_tab[r]) begin errors++; $display("FAIL inv_sbox_rand in=%h got %h want %h", r, sb_out, inv_tab[r]); end
    end
    step();
  endtask

  task automatic test_full_state();
    int n, busy_cnt;
    n = 0; busy_cnt = 0;
    out_ready = 1'b0;
    accept(128'h16161616_7C7C7C7C_10101010_D4D4D4D4);
    for (int c = 0; c < 40; c++) begin
      if (b4) busy_cnt++;
      if (v4) break;
      step();
      n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL full_latency got %0d want 4", n); end
    checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL full_busy_cycles got %0d want 4", busy_cnt); end
    checks++; if (o4 !== 128'hFFFFFFFF_01010101_7C7C7C7C_19191919) begin errors++; $display("FAIL full_state got %h want FFFFFFFF010101017C7C7C7C19191919", o4); end
    checks++; if (r4 !== 1'b0) begin errors++; $display("FAIL full_in_ready_done got %b want 0", r4); end
    out_ready = 1'b1;
    step();
    checks++; if (v4 !== 1'b0 || r4 !== 1'b1) begin errors++; $display("FAIL full_release got v=%b r=%b want v=0 r=1", v4, r4); end
    settle();
  endtask

  task automatic test_backpressure();
    logic [127:0] s;
    s = rand_state();
    out_ready = 1'b0;
    accept(s);
    for (int c = 0; c < 40 && !v4; c++) step();
    for (int i = 0; i < 10; i++) begin
      checks++; if (v4 !== 1'b1 || r4 !== 1'b0 || o4 !== exp_state(s)) begin
        errors++; $display("FAIL backpressure_hold cyc=%0d got v=%b r=%b out=%h want v=1 r=0 out=%h", i, v4, r4, o4, exp_state(s));
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (v4 !== 1'b0 || r4 !== 1'b1) begin errors++; $display("FAIL backpressure_release got v=%b r=%b want v=0 r=1", v4, r4); end
    settle();
  endtask

  task automatic test_reset_mid_op();
    logic [127:0] s;
    int n;
    out_ready = 1'b1;
    accept(rand_state());
    step();
    step();
    rst = 1'b1;
    step();
    checks++; if (r4 !== 1'b1 || v4 !== 1'b0 || b4 !== 1'b0 || o4 !== 128'h0) begin
      errors++; $display("FAIL midreset_state got r=%b v=%b b=%b out=%h want r=1 v=0 b=0 out=0", r4, v4, b4, o4);
    end
    rst = 1'b0;
    out_ready = 1'b0;
    s = rand_state();
    accept(s);
    n = 0;
    for (int c = 0; c < 40 && !v4; c++) begin step(); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL midreset_latency got %0d want 4", n); end
    checks++; if (o4 !== exp_state(s)) begin errors++; $display("FAIL midreset_result got %h want %h", o4, exp_state(s)); end
    settle();
  endtask

  task automatic test_busy_ignore();
    logic [127:0] s;
    int n;
    s = rand_state();
    out_ready = 1'b0;
    accept(s);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      state_in = rand_state();
      in_valid = 1'($urandom_range(0, 1));
      if (v4) break;
      step();
      n++;
    end
    in_valid = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL ignore_latency got %0d want 4", n); end
    checks++; if (o4 !== exp_state(s)) begin errors++; $display("FAIL ignore_result got %h want %h", o4, exp_state(s)); end
    settle();
  endtask

  task automatic test_back_to_back();
    logic [127:0] s;
    int first, second;
    first = -1; second = -1;
    s = rand_state();
    out_ready = 1'b1;
    state_in = s;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (v4) begin
        checks++; if (o4 !== exp_state(s)) begin errors++; $display("FAIL b2b_result got %h want %h", o4, exp_state(s)); end
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    in_valid = 1'b0;
    checks++; if (second - first !== 6 || first < 0) begin errors++; $display("FAIL b2b_period got %0d want 6", second - first); end
    settle();
  endtask

  task automatic test_sweep();
    logic [7:0] perm [256];
    logic [7:0] t;
    logic [127:0] x, s;
    int j, l1, l4, l16;
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin
        x[8*i +: 8] = perm[k*16 + i];
        s[8*i +: 8] = sbox_tab[perm[k*16 + i]];
      end
      out_ready = 1'b0;
      accept(s);
      l1 = -1; l4 = -1; l16 = -1;
      for (int c = 0; c <= 20; c++) begin
        if (v1 && l1 < 0) l1 = c;
        if (v4 && l4 < 0) l4 = c;
        if (v16 && l16 < 0) l16 = c;
        step();
      end
      checks++; if (l1 !== 16) begin errors++; $display("FAIL sweep_latency_bpc1 st=%0d got %0d want 16", k, l1); end
      checks++; if (l4 !== 4) begin errors++; $display("FAIL sweep_latency_bpc4 st=%0d got %0d want 4", k, l4); end
      checks++; if (l16 !== 1) begin errors++; $display("FAIL sweep_latency_bpc16 st=%0d got %0d want 1", k, l16); end
      checks++; if (o1 !== x) begin errors++; $display("FAIL sweep_bpc1 st=%0d got %h want %h", k, o1, x); end
      checks++; if (o4 !== x) begin errors++; $display("FAIL sweep_bpc4 st=%0d got %h want %h", k, o4, x); end
      checks++; if (o16 !== x) begin errors++; $display("FAIL sweep_bpc16 st=%0d got %h want %h", k, o16, x); end
      settle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; state_in = '0; sb_in = '0;
    build_tables();
    test_reset();
    test_inv_sbox();
    test_full_state();
    test_backpressure();
    test_reset_mid_op();
    test_busy_ignore();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_engine.md
Name: inv_sub_bytes_engine

Overview:
Iterative AES InvSubBytes engine for the decryption datapath. It is the inverse counterpart of the existing per-byte subBytes lookup.
- Accepts a full 128-bit AES state over a valid/ready handshake.
- Substitutes every byte through the inverse S-box, BYTES_PER_CYCLE bytes per clock.
- Presents the result on a valid/ready output port.
- Sits between InvShiftRows and AddRoundKey in the decryption round.

Parameters:
BYTES_PER_CYCLE, 4, bytes substituted per clock; legal values 1, 2, 4, 8, 16 (must divide 16; elaboration error otherwise)
NUM_STEPS, 16/BYTES_PER_CYCLE, derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  state_in valid
in_ready  output  1  engine can accept a state
state_in  input  128  ciphertext-side state; byte i = state_in[8*i+7 : 8*i]
out_valid  output  1  state_out holds a complete result
out_ready  input  1  downstream accepts the result
state_out  output  128  InvSubBytes(state_in), same byte ordering
busy  output  1  high while in BUSY

Behaviour:
- Clocking: single clock clk; reset rst is synchronous and active-high. All state updates occur on the rising edge.
- FSM states: IDLE, BUSY, DONE.
- Reset, or rst sampled high in any state:
  - state goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, step counter=0, state_out=128'h0.
  - Any in-flight operation is discarded; no partial result is ever presented.
- IDLE: in_ready=1.
  - On an edge with in_valid=1, latch state_in into the working register, clear the step counter, and go to BUSY.
  - in_valid=0 leaves the state in IDLE.
- BUSY: in_ready=0, busy=1.
  - Each edge replaces bytes [k*BPC .. k*BPC+BPC-1] of the working register with their inverse S-box values, where k is the step counter. Lowest-index bytes go first.
  - k increments by 1 each edge. The edge that processes k=NUM_STEPS-1 moves to DONE; the counter wraps to 0.
  - Input changes during BUSY are ignored.
- DONE: out_valid=1, state_out = working register, held stable until accepted.
  - On an edge with out_ready=1, go to IDLE (out_valid=0 next cycle).
  - Otherwise remain in DONE; this is backpressure.
- No overlap between input and output: in_ready is 0 in DONE. Throughput is one state per NUM_STEPS+2 cycles with out_ready tied high.
- Latency: out_valid rises NUM_STEPS cycles after the accepting edge (4 cycles at the default).
- BYTES_PER_CYCLE=16 gives a single BUSY cycle.
- Lookup is purely combinational from the working register; the only registers are the working register, the counter and the FSM.
- The engine never passes the input through unchanged: every byte is substituted exactly once.

Decomposition:
- Package aes_pkg:
  - typedef aes_state_t (logic [127:0]) and aes_byte_t (logic [7:0]).
  - FSM enum inv_sb_state_e {IDLE, BUSY, DONE}.
  - Constant AES_STATE_BYTES=16.
  - 256-entry INV_SBOX constant array, shared with future key-expansion and decryption blocks.
- Sub-module inv_sbox: one combinational byte lookup (aes_byte_t in, aes_byte_t out), indexing INV_SBOX. The engine instantiates BYTES_PER_CYCLE copies in a generate loop.

Test Plan:
- Single-byte inverses (inv_sbox standalone): D4->19, 10->7C, 63->00, 7C->01, 16->FF, 52->00 is not expected (52 is InvSbox(00)); check 00->52, FF->7D.
- Full state at default BPC=4: state_in=128'h16161616_7C7C7C7C_10101010_D4D4D4D4 -> state_out=128'hFFFFFFFF_01010101_7C7C7C7C_19191919. out_valid rises exactly 4 cycles after acceptance; busy=1 for those 4 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, state_out stable, in_ready=0. Then out_ready=1 for one edge -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-operation: assert rst at step k=2 -> next cycle IDLE, out_valid=0, state_out=0. A new state applied afterwards completes correctly in 4 cycles with no stale bytes.
- Inputs ignored while BUSY: change state_in and in_valid every cycle during BUSY -> the result matches only the originally accepted state.
- Parameter sweep BPC=1, 16: all 256 byte values over 16 states, compared against the scoreboard (InvSbox(Sbox(x))==x via the existing subBytes). Latency is 16 and 1 cycles respectively.
